// File: rtl/i2c_pkg.sv
// i2c_pkg: FSM state encoding, bus-level constants and a majority helper for the I2C target.
package i2c_pkg;
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } i2c_tgt_state_t;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/i2c_bus_sampler.sv
// i2c_bus_sampler: SCL/SDA synchronisers, optional 3-sample majority filter
// (I2C_TARGET_GLITCH_FILTER_EN), and SCL edge / START / STOP detection.
module i2c_bus_sampler import i2c_pkg::*; #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_q, sda_q;

  // Reset to the idle-bus level so release from reset never looks like an edge.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_h, sda_h;
  logic scl_f, sda_f;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      scl_h <= '1;
      sda_h <= '1;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
    end else begin
      scl_h <= {scl_h[0], scl_sync[SYNC_STAGES-1]};
      sda_h <= {sda_h[0], sda_sync[SYNC_STAGES-1]};
      scl_f <= maj3(scl_h[1], scl_h[0], scl_sync[SYNC_STAGES-1]);
      sda_f <= maj3(sda_h[1], sda_h[0], sda_sync[SYNC_STAGES-1]);
    end
  assign scl_s = scl_f;
  assign sda_s = sda_f;
`else
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_s;
      sda_q <= sda_s;
    end

  assign sda       = sda_s;
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s & ~start_det;
endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target endpoint with 7-bit address match, byte write delivery and read shift-out.
// Build option I2C_TARGET_GLITCH_FILTER_EN adds a majority glitch filter in i2c_bus_sampler.
module i2c_target import i2c_pkg::*; #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       stop_det
);
  i2c_tgt_state_t state_q, state_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic [2:0] cnt_q, cnt_d;
  logic sda_oe_d, busy_d, rw_q, rw_d, mack_q, mack_d;
  logic sda, scl_rise, scl_fall, start_det, addr_hit, last_bit;

  i2c_bus_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  assign addr_hit = shift_q[6:0] == TARGET_ADDR;
  assign last_bit = scl_rise && cnt_q == 3'd0;
  assign rx_data  = rx_data_d;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      rx_data_q <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      rw_q      <= I2C_RW_WRITE;
      mack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      rx_data_q <= rx_data_d;
      sda_oe    <= sda_oe_d;
      busy      <= busy_d;
      rw_q      <= rw_d;
      mack_q    <= mack_d;
    end

  // In the ACK states sda_oe itself marks whether the ACK is already on the bus.
  always_comb begin
    state_d = state_q;
    if (start_det) state_d = ADDR;
    else if (stop_det) state_d = IDLE;
    else
      case (state_q)
        ADDR:     if (last_bit) state_d = addr_hit ? ADDR_ACK : IDLE;
        ADDR_ACK: if (scl_fall && sda_oe) state_d = rw_q == I2C_RW_READ ? RD_DATA : WR_DATA;
        WR_DATA:  if (last_bit) state_d = WR_ACK;
        WR_ACK:   if (scl_fall && sda_oe) state_d = WR_DATA;
        RD_DATA:  if (last_bit) state_d = RD_ACK;
        RD_ACK:   state_d = scl_rise && sda == I2C_NACK ? IDLE : scl_fall && mack_q ? RD_DATA : RD_ACK;
        default:  state_d = state_q;
      endcase
  end

  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    rx_data_d = rx_data_q;
    sda_oe_d  = sda_oe;
    busy_d    = busy;
    rw_d      = rw_q;
    mack_d    = mack_q;
    rx_valid  = 1'b0;
    tx_req    = 1'b0;
    if (start_det) begin
      cnt_d    = 3'd7;
      sda_oe_d = 1'b0;
      mack_d   = 1'b0;
    end else if (stop_det) begin
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      mack_d   = 1'b0;
    end else
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda};
          cnt_d   = cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            rw_d   = sda;
            busy_d = addr_hit;
          end
        end
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          sda_oe_d = ~sda_oe;
          cnt_d    = 3'd7;
          if (sda_oe && state_q == ADDR_ACK && rw_q == I2C_RW_READ) begin
            tx_req   = 1'b1;
            shift_d  = tx_data;
            sda_oe_d = ~tx_data[7];
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda};
          cnt_d   = cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            rx_valid  = 1'b1;
            rx_data_d = {shift_q[6:0], sda};
          end
        end
        RD_DATA:
          if (scl_rise) begin
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q - 3'd1;
          end else if (scl_fall) sda_oe_d = ~shift_q[7];
        RD_ACK:
          if (scl_rise) begin
            mack_d = sda == I2C_ACK;
            busy_d = sda == I2C_ACK;
          end else if (scl_fall) begin
            sda_oe_d = 1'b0;
            if (mack_q) begin
              tx_req   = 1'b1;
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[7];
              cnt_d    = 3'd7;
              mack_d   = 1'b0;
            end
          end
        default: ;
      endcase
  end
endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) endpoint for the on-chip I2C bus, the responder side of the I2C master FSM. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, and acknowledges it. It then delivers written bytes to the host logic, or shifts out host-supplied bytes on reads. SDA is open-drain: the block only ever pulls low.

## Interface
- `TARGET_ADDR`, default 7'h50: 7-bit bus address this target answers.
- `SYNC_STAGES`, default 2: flops in the SCL/SDA input synchronisers (≥2).
- `clk` in 1: system clock, ≥8× SCL frequency.
- `reset_n` in 1: asynchronous, active-low reset.
- `scl_in` in 1: bus SCL, asynchronous.
- `sda_in` in 1: bus SDA, asynchronous.
- `sda_oe` out 1: 1 = pull SDA low; 0 = release.
- `rx_data` out 8: last byte written by the master.
- `rx_valid` out 1: 1-cycle pulse; `rx_data` is valid this cycle.
- `tx_data` in 8: byte to return on a read; sampled when `tx_req` pulses.
- `tx_req` out 1: 1-cycle pulse; the host must present `tx_data` in the same cycle (combinational or held register).
- `busy` out 1: 1 from an address-matched START until STOP or NACK termination.
- `stop_det` out 1: 1-cycle pulse on any detected STOP.

## Operation
- Inputs are synchronised, then edge-detected: `scl_rise`, `scl_fall`. START is SDA falling while SCL is high; STOP is SDA rising while SCL is high.
- Data is sampled on `scl_rise`. `sda_oe` changes only on `scl_fall`, which gives setup for the next high phase.
- Bit counter is 3 bits, MSB first, and counts 7 down to 0.
- States (enum in package):
  - IDLE: `sda_oe`=0; START → ADDR.
  - ADDR: shift 8 bits (7 address + R/W). After bit 0:
    - Match → ADDR_ACK, `busy`=1.
    - Mismatch → IDLE. The block ignores the bus until the next START.
  - ADDR_ACK: on `scl_fall`, `sda_oe`=1 for one SCL period. On the following `scl_fall`:
    - R/W=0 → WR_DATA, `sda_oe`=0.
    - R/W=1 → RD_DATA. `tx_req` pulses at entry, `tx_data` is loaded into the shift register, MSB is driven.
  - WR_DATA: shift 8 bits. After bit 0: `rx_data` updated, `rx_valid` pulse → WR_ACK.
  - WR_ACK: drive ACK for one SCL period → WR_DATA.
  - RD_DATA: `sda_oe` = ~shift[7] on each `scl_fall`. After 8 bits → RD_ACK with SDA released.
  - RD_ACK: sample the master's bit on `scl_rise`:
    - 0 (ACK): next `scl_fall` → `tx_req` pulse, reload, → RD_DATA.
    - 1 (NACK) → IDLE, `busy`=0.
- STOP in any state → IDLE, `sda_oe`=0, `busy`=0, `stop_det` pulse, bit counter cleared.
- START in any non-IDLE state (repeated START) → ADDR with the counter reset. `busy` is held until the new address resolves.
- START and STOP cannot be detected in the same cycle. If both SDA edge conditions appear, START wins.
- Reset values: `sda_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `busy`=0, `stop_det`=0, state IDLE. A reset mid-transfer releases SDA immediately (asynchronous).

## Timing
- Input latency: a bus edge is seen `SYNC_STAGES`+1 clk later; `SYNC_STAGES`+3 with the filter enabled.
- `rx_valid`: the same clk the 8th data bit's `scl_rise` is detected.
- ACK drive: asserted on the first `scl_fall` detection after the 8th bit; released on the next `scl_fall` detection.
- `tx_req` to first driven bit: 0 clk. Load and drive happen in the same cycle as the `scl_fall` detection.
- No clock stretching. The host must always have `tx_data` ready.

## Configuration
- `I2C_TARGET_GLITCH_FILTER_EN`:
  - Defined: a 3-sample majority filter follows each synchroniser. Pulses of 1 clk are rejected.
  - Undefined: synchroniser outputs are used directly.

## Structure
- Package `i2c_pkg` holds:
  - the `i2c_tgt_state_t` enum;
  - constants `I2C_ACK`=1'b0, `I2C_NACK`=1'b1, `I2C_RW_WRITE`=1'b0, `I2C_RW_READ`=1'b1.
- Sub-module `i2c_bus_sampler`: synchroniser, optional filter, and `scl_rise`/`scl_fall`/START/STOP detection. It is instantiated once.
- The top level holds the FSM, shift register, and bit counter.

## Test plan
- Write to 7'h50 with byte 8'hA5 → ACK on the address and on the data; `rx_valid` once with `rx_data`=8'hA5; STOP → `stop_det` pulse, `busy`=0.
- Write to 7'h51 → no ACK (SDA stays high at the 9th clock); `rx_valid` never pulses; `busy` stays 0.
- Read from 7'h50 with `tx_data`=8'h3C then 8'hC3, master ACKs then NACKs → bus shows 8'h3C, 8'hC3; `tx_req` pulses twice; IDLE after the NACK.
- Write 8'h12, then repeated START, read → `rx_data`=8'h12; re-addressing succeeds; the first read byte equals `tx_data` at the repeated-START `tx_req`.
- STOP injected after bit 4 of a write data byte → IDLE; no `rx_valid`; `sda_oe`=0.
- `reset_n` low during an ACK drive → `sda_oe`=0 within the same cycle. With `I2C_TARGET_GLITCH_FILTER_EN` defined, a 1-clk SCL glitch is not counted as a bit.
